sram_arbiter_rr: RTL and testbench



---
 rtl/sram_arbiter_pkg.sv | 15 +
 rtl/sram_arb_rr2.sv | 42 ++++
 rtl/sram_arbiter_rr.sv | 145 ++++++++++++++
 tb/tb_sram_arbiter_rr.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port async SRAM arbiter.
package sram_arbiter_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWr,
      StWrEnd,
      StRd,
      StRdCap
   } state_e;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-way round-robin grant: a lone requester wins, ties go to the port not served last.
module sram_arb_rr2
   import sram_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic       grant,
   output logic       last_grant
);

   logic last_grant_q, last_grant_d;

   // Grant decode from current requests and the previous winner.
   always_comb begin
      grant = PORT0;
      case (valid)
         2'b01:   grant = PORT0;
         2'b10:   grant = PORT1;
         2'b11:   grant = ~last_grant_q;
         default: grant = PORT0;
      endcase
   end

   // Winner is remembered only when its command is actually taken.
   always_comb begin
      last_grant_d = accept ? grant : last_grant_q;
   end

   // Reset to PORT1 so port 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_q <= PORT1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   assign last_grant = last_grant_q;

endmodule

// File: rtl/sram_arbiter_rr.sv
// Shares one async SRAM between two valid/ready command ports with fixed 2-cycle ops.
module sram_arbiter_rr
   import sram_arbiter_pkg::*;
#(
   parameter int unsigned SRAM_ADDR_WIDTH = 20,
   parameter int unsigned SRAM_DATA_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       m0_cmd_valid,
   output logic                       m0_cmd_ready,
   input  logic                       m0_cmd_wr,
   input  logic [SRAM_ADDR_WIDTH-1:0] m0_cmd_addr,
   input  logic [SRAM_DATA_WIDTH-1:0] m0_cmd_wdata,
   output logic                       m0_rd_valid,
   output logic [SRAM_DATA_WIDTH-1:0] m0_rd_data,
   input  logic                       m1_cmd_valid,
   output logic                       m1_cmd_ready,
   input  logic                       m1_cmd_wr,
   input  logic [SRAM_ADDR_WIDTH-1:0] m1_cmd_addr,
   input  logic [SRAM_DATA_WIDTH-1:0] m1_cmd_wdata,
   output logic                       m1_rd_valid,
   output logic [SRAM_DATA_WIDTH-1:0] m1_rd_data,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_io_addr,
   inout  wire  [SRAM_DATA_WIDTH-1:0] sram_io_data,
   output logic                       sram_io_we_n,
   output logic                       sram_io_oe_n,
   output logic                       sram_io_ce_n
);

   state_e                     state_q, state_d;
   logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [SRAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                       owner_q, owner_d;
   logic                       ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
   logic                       drive_q, drive_d;
   logic [SRAM_DATA_WIDTH-1:0] rd_data0_q, rd_data0_d, rd_data1_q, rd_data1_d;
   logic                       rd_valid0_q, rd_valid0_d, rd_valid1_q, rd_valid1_d;

   logic                       grant, last_grant, accept, is_idle;
   logic                       sel_wr;
   logic [SRAM_ADDR_WIDTH-1:0] sel_addr;
   logic [SRAM_DATA_WIDTH-1:0] sel_wdata;

   sram_arb_rr2 u_rr2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid      ({m1_cmd_valid, m0_cmd_valid}),
      .accept     (accept),
      .grant      (grant),
      .last_grant (last_grant)
   );

   assign is_idle      = (state_q == StIdle);
   assign m0_cmd_ready = is_idle && m0_cmd_valid && (grant == PORT0);
   assign m1_cmd_ready = is_idle && m1_cmd_valid && (grant == PORT1);
   assign accept       = (m0_cmd_valid && m0_cmd_ready) || (m1_cmd_valid && m1_cmd_ready);

   assign sel_wr    = (grant == PORT1) ? m1_cmd_wr    : m0_cmd_wr;
   assign sel_addr  = (grant == PORT1) ? m1_cmd_addr  : m0_cmd_addr;
   assign sel_wdata = (grant == PORT1) ? m1_cmd_wdata : m0_cmd_wdata;

   // Op sequencing, command latch, read capture; pins decoded from the next state.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      owner_d     = owner_q;
      rd_data0_d  = rd_data0_q;
      rd_data1_d  = rd_data1_q;
      rd_valid0_d = 1'b0;
      rd_valid1_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               owner_d = grant;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               state_d = sel_wr ? StWr : StRd;
            end
         end
         StWr:    state_d = StWrEnd;
         StWrEnd: state_d = StIdle;
         StRd:    state_d = StRdCap;
         StRdCap: begin
            state_d = StIdle;
            if (owner_q == PORT1) begin
               rd_valid1_d = 1'b1;
               rd_data1_d  = sram_io_data;
            end else begin
               rd_valid0_d = 1'b1;
               rd_data0_d  = sram_io_data;
            end
         end
         default: state_d = StIdle;
      endcase
      // Registered pins take the values of the state being entered.
      ce_n_d  = (state_d == StIdle);
      we_n_d  = (state_d != StWr);
      oe_n_d  = !((state_d == StRd) || (state_d == StRdCap));
      drive_d = (state_d == StWr) || (state_d == StWrEnd);
   end

   // State, pin and read-return registers with synchronous reset to idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         wdata_q     <= '0;
         owner_q     <= PORT0;
         ce_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         drive_q     <= 1'b0;
         rd_data0_q  <= '0;
         rd_data1_q  <= '0;
         rd_valid0_q <= 1'b0;
         rd_valid1_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         owner_q     <= owner_d;
         ce_n_q      <= ce_n_d;
         we_n_q      <= we_n_d;
         oe_n_q      <= oe_n_d;
         drive_q     <= drive_d;
         rd_data0_q  <= rd_data0_d;
         rd_data1_q  <= rd_data1_d;
         rd_valid0_q <= rd_valid0_d;
         rd_valid1_q <= rd_valid1_d;
      end
   end

   assign sram_io_addr = addr_q;
   assign sram_io_ce_n = ce_n_q;
   assign sram_io_we_n = we_n_q;
   assign sram_io_oe_n = oe_n_q;
   assign sram_io_data = drive_q ? wdata_q : {SRAM_DATA_WIDTH{1'bz}};
   assign m0_rd_valid  = rd_valid0_q;
   assign m0_rd_data   = rd_data0_q;
   assign m1_rd_valid  = rd_valid1_q;
   assign m1_rd_data   = rd_data1_q;

endmodule

// File: tb/tb_sram_arbiter_rr.sv
// Bench for sram_arbiter_rr: async SRAM model, transaction-level reference model, directed ops.
module tb_sram_arbiter_rr;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [1:0]       vld = '0;
   logic [1:0]       wr = '0;
   logic [1:0][7:0]  ad = '0;
   logic [1:0][15:0] wd = '0;
   logic [1:0]       rdy;
   logic [1:0]       rv;
   logic [1:0][15:0] rd;
   logic [7:0]       s_addr;
   wire  [15:0]      sram_data;
   logic             s_we_n, s_oe_n, s_ce_n;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int cnt_rv [2] = '{0, 0};

   sram_arbiter_rr #(
      .SRAM_ADDR_WIDTH (8),
      .SRAM_DATA_WIDTH (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .m0_cmd_valid (vld[0]),
      .m0_cmd_ready (rdy[0]),
      .m0_cmd_wr    (wr[0]),
      .m0_cmd_addr  (ad[0]),
      .m0_cmd_wdata (wd[0]),
      .m0_rd_valid  (rv[0]),
      .m0_rd_data   (rd[0]),
      .m1_cmd_valid (vld[1]),
      .m1_cmd_ready (rdy[1]),
      .m1_cmd_wr    (wr[1]),
      .m1_cmd_addr  (ad[1]),
      .m1_cmd_wdata (wd[1]),
      .m1_rd_valid  (rv[1]),
      .m1_rd_data   (rd[1]),
      .sram_io_addr (s_addr),
      .sram_io_data (sram_data),
      .sram_io_we_n (s_we_n),
      .sram_io_oe_n (s_oe_n),
      .sram_io_ce_n (s_ce_n)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Async SRAM part: drives on ce&oe with we high, writes at the clock edge while we is low.
   logic [15:0] sram_mem [256];
   assign sram_data = (!s_ce_n && !s_oe_n && s_we_n) ? sram_mem[s_addr] : 16'hzzzz;
   always @(posedge clk) if (!s_ce_n && !s_we_n) sram_mem[s_addr] <= sram_data;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: an accepted op is busy for two cycles, read data returns on the third.
   int          m_ph = 0;
   bit          m_ok = 0;
   bit          m_wr, m_own, m_lg;
   logic [7:0]  m_addr;
   logic [15:0] m_wd;
   logic [15:0] m_mem [256];
   logic [15:0] m_rdd [2];
   bit          m_rdv [2];

   always @(negedge clk) begin
      bit         g;
      logic [1:0] e_rdy;
      g = (vld == 2'b11) ? !m_lg : vld[1];
      e_rdy = '0;
      if (m_ph == 0 && vld != 2'b00) e_rdy[g] = 1'b1;
      if (rv[0]) cnt_rv[0]++;
      if (rv[1]) cnt_rv[1]++;
      if (m_ok) begin
         chk("ready", {30'd0, rdy}, {30'd0, e_rdy});
         chk("ce_n", s_ce_n, m_ph == 0);
         chk("we_n", s_we_n, !(m_ph == 1 && m_wr));
         chk("oe_n", s_oe_n, !(m_ph != 0 && !m_wr));
         chk("addr", s_addr, m_addr);
         chk("rd_valid0", rv[0], m_rdv[0]);
         chk("rd_valid1", rv[1], m_rdv[1]);
         chk("rd_data0", rd[0], m_rdd[0]);
         chk("rd_data1", rd[1], m_rdd[1]);
         if (m_ph != 0 && m_wr) chk("bus_wdata", sram_data, m_wd);
         if (!s_oe_n && !s_ce_n) chk("no_contention", sram_data, sram_mem[s_addr]);
      end
      if (!rst_n) begin
         m_ok = 1; m_ph = 0; m_lg = 1; m_addr = '0;
         m_rdv[0] = 0; m_rdv[1] = 0; m_rdd[0] = '0; m_rdd[1] = '0;
      end else if (m_ok) begin
         m_rdv[0] = 0; m_rdv[1] = 0;
         if (m_ph == 2 && !m_wr) begin
            m_rdv[m_own] = 1;
            m_rdd[m_own] = m_mem[m_addr];
         end
         if (m_ph == 0) begin
            if (vld != 2'b00) begin
               m_ph = 1; m_lg = g; m_own = g;
               m_wr = wr[g]; m_addr = ad[g]; m_wd = wd[g];
               if (wr[g]) m_mem[ad[g]] = wd[g];
            end
         end else begin
            m_ph = (m_ph == 2) ? 0 : m_ph + 1;
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Issue one command and hold it until accepted; returns the accept cycle (or -1).
   task automatic cmd(input int p, input bit w, input logic [7:0] a, input logic [15:0] d,
                      output int acc);
      int n = 0;
      acc = -1;
      vld[p] = 1'b1; wr[p] = w; ad[p] = a; wd[p] = d;
      do begin
         @(negedge clk);
         n++;
      end while (!rdy[p] && n < 200);
      if (!rdy[p]) begin
         chk("cmd_timeout", 0, 1);
         vld[p] = 1'b0;
         sync();
         return;
      end
      acc = cyc;
      sync();
      // Scramble the inputs while the op runs: the arbiter must use its latched copy.
      vld[p] = 1'b0; wr[p] = ~w; ad[p] = ~a; wd[p] = ~d;
   endtask

   // Hand-computed pin sequence and read return for one op accepted at cycle acc.
   task automatic check_op(input int p, input bit w, input int acc, input logic [15:0] d);
      if (acc < 0) return;
      for (int j = 1; j <= 3; j++) begin
         do @(negedge clk); while (cyc < acc + j);
         if (w) begin
            chk("op_wr_ce_n", s_ce_n, j == 3);
            chk("op_wr_we_n", s_we_n, j != 1);
            chk("op_wr_oe_n", s_oe_n, 1);
            if (j < 3) chk("op_wr_bus", sram_data, d);
         end else begin
            chk("op_rd_ce_n", s_ce_n, j == 3);
            chk("op_rd_oe_n", s_oe_n, j == 3);
            chk("op_rd_we_n", s_we_n, 1);
            chk("op_rd_valid", rv[p], j == 3);
            chk("op_rd_other", rv[1-p], 0);
            if (j == 3) chk("op_rd_data", rd[p], d);
         end
      end
   endtask

   initial begin
      int a, a0, a1, b, f0, prev, c0, c1;
      for (int i = 0; i < 256; i++) begin
         sram_mem[i] = '0;
         m_mem[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ce_n", s_ce_n, 1);
      chk("rst_we_n", s_we_n, 1);
      chk("rst_oe_n", s_oe_n, 1);
      chk("rst_addr", s_addr, 0);
      chk("rst_rd_data0", rd[0], 0);
      chk("rst_rd_valid", {30'd0, rv}, 0);
      sync();

      // Single-port write then read.
      cmd(0, 1, 8'h10, 16'hA5A5, a);
      check_op(0, 1, a, 16'hA5A5);
      sync();
      cmd(0, 0, 8'h10, 16'h0000, a);
      check_op(0, 0, a, 16'hA5A5);
      sync();

      // Tie on writes after reset: port 0 first.
      rst_n = 1'b0;
      sync();
      rst_n = 1'b1;
      fork
         cmd(0, 1, 8'h20, 16'h1111, a0);
         cmd(1, 1, 8'h21, 16'h2222, a1);
      join
      chk("tie_wr_order", a1 - a0, 3);
      // Lone port-0 read leaves last_grant at port 0, so the next tie goes to port 1.
      cmd(0, 0, 8'h20, 16'h0000, a);
      check_op(0, 0, a, 16'h1111);
      sync();
      fork
         begin
            cmd(0, 0, 8'h20, 16'h0000, a0);
            check_op(0, 0, a0, 16'h1111);
         end
         begin
            cmd(1, 0, 8'h21, 16'h0000, a1);
            check_op(1, 0, a1, 16'h2222);
         end
      join
      chk("tie_rd_order", a0 - a1, 3);
      sync();

      // Streaming writes at full rate, then interleaved reads from both ports.
      prev = 0;
      for (int i = 0; i < 256; i++) begin
         cmd(0, 1, 8'(i), 16'(i * 3), a);
         if (i > 0) chk("wr_throughput", a - prev, 3);
         prev = a;
      end
      c0 = cnt_rv[0];
      c1 = cnt_rv[1];
      fork
         begin
            int p0 = 0;
            for (int k = 0; k < 128; k++) begin
               int x;
               cmd(0, 0, 8'(2 * k), 16'h0000, x);
               if (k > 0) chk("rd_throughput0", x - p0, 6);
               p0 = x;
            end
         end
         begin
            int p1 = 0;
            for (int k = 0; k < 128; k++) begin
               int x;
               cmd(1, 0, 8'(2 * k + 1), 16'h0000, x);
               if (k > 0) chk("rd_throughput1", x - p1, 6);
               p1 = x;
            end
         end
      join
      repeat (4) sync();
      chk("stream_rd_count0", cnt_rv[0] - c0, 128);
      chk("stream_rd_count1", cnt_rv[1] - c1, 128);

      // Port 1 holds a read while port 0 streams reads.
      cmd(0, 1, 8'h30, 16'hBEEF, a);
      f0 = -1;
      b = -1;
      fork
         begin
            for (int k = 0; k < 4; k++) begin
               int x;
               cmd(0, 0, 8'(k), 16'h0000, x);
               if (k == 0) f0 = x;
            end
         end
         begin
            cmd(1, 0, 8'h30, 16'h0000, b);
            check_op(1, 0, b, 16'hBEEF);
         end
      join
      chk("bp_m1_within_2_ops", (b >= 0) && (b <= f0 + 3), 1);
      repeat (3) sync();

      // Reset while in RD: pins idle next cycle, no read return, port 0 wins afterwards.
      cmd(1, 0, 8'h21, 16'h0000, a);
      rst_n = 1'b0;
      sync();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstmid_ce_n", s_ce_n, 1);
      chk("rstmid_oe_n", s_oe_n, 1);
      chk("rstmid_we_n", s_we_n, 1);
      for (int k = 0; k < 3; k++) begin
         chk("rstmid_no_rd_valid", {30'd0, rv}, 0);
         @(negedge clk);
      end
      sync();
      fork
         cmd(0, 0, 8'h20, 16'h0000, a0);
         cmd(1, 0, 8'h21, 16'h0000, a1);
      join
      chk("rstmid_next_grant_m0", a1 - a0, 3);
      repeat (5) sync();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
